// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer: FETCH/DECODE/EXEC/MEM/WB with ack timeouts.
// Define SEQ_PERF_CNT_EN to build the cycle_cnt/instret performance counters.
module stage_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  opcode,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        if_en,
  output logic        id_en,
  output logic        ex_en,
  output logic        br_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic        bus_err,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // The wait counter holds (cycles spent waiting - 1), so this is the last cycle an ack is accepted.
  localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  function automatic logic is_xfer(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

  state_t     state_q;
  logic [6:0] op_q;
  logic [7:0] wait_q;
  logic       pc_we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= 7'd0;
      wait_q   <= 8'd0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      id_en    <= 1'b0;
      ex_en    <= 1'b0;
      br_en    <= 1'b0;
      wb_en    <= 1'b0;
      pc_we_q  <= 1'b0;
      pc_sel   <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      id_en   <= 1'b0;
      ex_en   <= 1'b0;
      br_en   <= 1'b0;
      wb_en   <= 1'b0;
      pc_we_q <= 1'b0;
      pc_sel  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
            wait_q   <= 8'd0;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            id_en    <= 1'b1;
            state_q  <= DECODE;
          end else if (wait_q == WAIT_LAST) begin
            imem_req <= 1'b0;
            bus_err  <= 1'b1;
            halted   <= 1'b1;
            busy     <= 1'b0;
            state_q  <= HALT;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        DECODE: begin
          op_q <= opcode;
          if (is_legal(opcode)) begin
            state_q <= EXEC;
            ex_en   <= 1'b1;
            br_en   <= is_xfer(opcode);
            pc_we_q <= is_xfer(opcode);
            pc_sel  <= is_xfer(opcode);
          end else begin
            state_q <= HALT;
            halted  <= 1'b1;
            busy    <= 1'b0;
            illegal <= (opcode != OP_SYSTEM);
          end
        end
        EXEC: begin
          if (op_q == OP_LOAD || op_q == OP_STORE) begin
            state_q  <= MEM;
            dmem_req <= 1'b1;
            dmem_we  <= (op_q == OP_STORE);
            wait_q   <= 8'd0;
          end else if (is_xfer(op_q)) begin
            state_q  <= FETCH;
            imem_req <= 1'b1;
            wait_q   <= 8'd0;
          end else begin
            state_q <= WB;
            wb_en   <= 1'b1;
            pc_we_q <= 1'b1;
          end
        end
        MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (op_q == OP_STORE) begin
              state_q  <= FETCH;
              imem_req <= 1'b1;
              wait_q   <= 8'd0;
            end else begin
              state_q <= WB;
              wb_en   <= 1'b1;
              pc_we_q <= 1'b1;
            end
          end else if (wait_q == WAIT_LAST) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            bus_err  <= 1'b1;
            halted   <= 1'b1;
            busy     <= 1'b0;
            state_q  <= HALT;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        WB: begin
          state_q  <= FETCH;
          imem_req <= 1'b1;
          wait_q   <= 8'd0;
        end
        HALT: begin
          state_q <= HALT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ack-cycle strobes must land in the same cycle as the ack, so they qualify the held request.
  assign if_en  = imem_req & imem_ack;
  assign mem_en = dmem_req & dmem_ack;
  assign pc_we  = pc_we_q | (mem_en & dmem_we);

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_q;
  logic [31:0] instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      if (busy)  cycle_q   <= cycle_q + 32'd1;
      if (pc_we) instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_q;
  assign instret   = instret_q;
`else
  assign cycle_cnt = 32'd0;
  assign instret   = 32'd0;
`endif

endmodule
